// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - shared types and constants for the serial deserializer
// Purpose: FSM state encoding and default framing constants used by the
//          deserializer top and its sync detector.
// Ports:   none (package).
package serdes_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } des_state_t;

  localparam int         SERDES_BYTE_W       = 8;
  localparam logic [7:0] SERDES_SYNC_DEFAULT = 8'hBC;

endpackage

// File: rtl/serdes_sync_det.sv
// rtl/serdes_sync_det.sv - combinational sync character detector
// Purpose: flags when the current 8-bit window equals the sync character.
// Ports:
//   window  in  8  most recent 8 serial bits, newest in bit 0
//   match   out 1  window equals SYNC_BYTE
module serdes_sync_det
  import serdes_pkg::*;
#(
  parameter logic [SERDES_BYTE_W-1:0] SYNC_BYTE = SERDES_SYNC_DEFAULT
) (
  input  logic [SERDES_BYTE_W-1:0] window,
  output logic                     match
);

  assign match = (window == SYNC_BYTE);

endmodule

// File: rtl/serdes_deserializer.sv
// rtl/serdes_deserializer.sv - serial-to-byte deserializer with sync-byte alignment
// Purpose: hunts for SYNC_BYTE at any bit offset, then delivers aligned data
//          bytes and drops lock after more than MAX_GAP bytes without a sync.
// Optional: SERDES_DESERIALIZER_ERRCNT_EN adds a saturating lock-loss counter.
// Ports:
//   clk           in  1  clock, one serial bit per rising edge
//   rst           in  1  asynchronous active-low reset
//   serial_in     in  1  serial data, MSB first
//   parallel_out  out 8  last delivered data byte
//   out_valid     out 1  strobe: new byte on parallel_out
//   locked        out 1  byte alignment established
//   sync_seen     out 1  strobe: aligned sync byte received
//   lock_lost     out 1  strobe: lock dropped on gap overflow
//   err_count     out 8  (optional) saturating count of lock losses
module serdes_deserializer
  import serdes_pkg::*;
#(
  parameter logic [SERDES_BYTE_W-1:0] SYNC_BYTE = SERDES_SYNC_DEFAULT,
  parameter int                       MAX_GAP   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     serial_in,
  output logic [SERDES_BYTE_W-1:0] parallel_out,
  output logic                     out_valid,
  output logic                     locked,
  output logic                     sync_seen,
  output logic                     lock_lost
`ifdef SERDES_DESERIALIZER_ERRCNT_EN
  ,
  output logic [7:0]               err_count
`endif
);

  localparam int             GAP_W   = $clog2(MAX_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(MAX_GAP);

  des_state_t                      state;
  // Only the seven previous bits are kept: the eighth bit of the window is
  // always the live serial_in, so a stored copy of it would never be read.
  logic [SERDES_BYTE_W-2:0]        shreg;
  logic [2:0]                      bit_cnt;
  logic [GAP_W-1:0]                gap_cnt;
  logic [SERDES_BYTE_W-1:0]        window;
  logic                            match;
  logic                            at_boundary;
  logic                            lose_lock;

  assign window      = {shreg, serial_in};
  assign at_boundary = (state == LOCKED) && (bit_cnt == 3'd7);
  assign lose_lock   = at_boundary && !match && (gap_cnt >= GAP_MAX);

  serdes_sync_det #(
    .SYNC_BYTE (SYNC_BYTE)
  ) u_sync_det (
    .window (window),
    .match  (match)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= HUNT;
      shreg        <= '0;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      parallel_out <= '0;
      out_valid    <= 1'b0;
      locked       <= 1'b0;
      sync_seen    <= 1'b0;
      lock_lost    <= 1'b0;
    end else begin
      shreg     <= window[SERDES_BYTE_W-2:0];
      out_valid <= 1'b0;
      sync_seen <= 1'b0;
      lock_lost <= 1'b0;
      case (state)
        HUNT: begin
          if (match) begin
            state     <= LOCKED;
            locked    <= 1'b1;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            sync_seen <= 1'b1;
          end
        end
        LOCKED: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (at_boundary) begin
            if (match) begin
              sync_seen <= 1'b1;
              gap_cnt   <= '0;
            end else if (lose_lock) begin
              // Byte is discarded; its bits stay in shreg for the re-hunt.
              state     <= HUNT;
              locked    <= 1'b0;
              lock_lost <= 1'b1;
              gap_cnt   <= '0;
            end else begin
              parallel_out <= window;
              out_valid    <= 1'b1;
              gap_cnt      <= gap_cnt + GAP_W'(1);
            end
          end
        end
        default: begin
          state  <= HUNT;
          locked <= 1'b0;
        end
      endcase
    end
  end

`ifdef SERDES_DESERIALIZER_ERRCNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_count <= 8'h00;
    end else if (lose_lock && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_serdes_deserializer.sv
// tb/tb_serdes_deserializer.sv - self-checking bench for serdes_deserializer
module tb_serdes_deserializer;

  localparam logic [7:0] SYNC    = 8'hBC;
  localparam int         MAX_GAP = 4;

  logic       clk       = 1'b0;
  logic       rst       = 1'b0;
  logic       serial_in = 1'b0;
  logic [7:0] parallel_out;
  logic       out_valid;
  logic       locked;
  logic       sync_seen;
  logic       lock_lost;
`ifdef SERDES_DESERIALIZER_ERRCNT_EN
  logic [7:0] err_count;
`endif

  int passed = 0;
  int total  = 0;

  serdes_deserializer #(
    .SYNC_BYTE (SYNC),
    .MAX_GAP   (MAX_GAP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .parallel_out (parallel_out),
    .out_valid    (out_valid),
    .locked       (locked),
    .sync_seen    (sync_seen),
    .lock_lost    (lock_lost)
`ifdef SERDES_DESERIALIZER_ERRCNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: tracks the bit history as an integer and counts bits
  // since the last lock; a byte completes every 8th bit after the lock point.
  int         m_hist  = 0;
  int         m_since = 0;
  int         m_gap   = 0;
  bit         m_lock  = 1'b0;
  logic [7:0] e_par   = 8'h00;
  bit         e_val   = 1'b0;
  bit         e_sync  = 1'b0;
  bit         e_lost  = 1'b0;
  int         e_err   = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_hist = 0; m_since = 0; m_gap = 0; m_lock = 1'b0;
      e_par = 8'h00; e_val = 1'b0; e_sync = 1'b0; e_lost = 1'b0; e_err = 0;
    end else begin
      m_hist = ((m_hist << 1) | int'(serial_in)) & 32'hFF;
      e_val = 1'b0; e_sync = 1'b0; e_lost = 1'b0;
      if (!m_lock) begin
        if (m_hist == int'(SYNC)) begin
          m_lock = 1'b1; m_since = 0; m_gap = 0; e_sync = 1'b1;
        end
      end else begin
        m_since++;
        if (m_since % 8 == 0) begin
          if (m_hist == int'(SYNC)) begin
            e_sync = 1'b1; m_gap = 0;
          end else if (m_gap < MAX_GAP) begin
            e_par = 8'(m_hist); e_val = 1'b1; m_gap++;
          end else begin
            m_lock = 1'b0; e_lost = 1'b1; m_gap = 0;
            if (e_err < 255) e_err++;
          end
        end
      end
    end
  end

  // Per-cycle comparison plus a log of delivered bytes and strobe counts.
  logic [7:0] got[$];
  int n_sync = 0;
  int n_lost = 0;

  always @(negedge clk) begin
    check("parallel_out", parallel_out, e_par);
    check("out_valid", out_valid, e_val);
    check("locked", locked, m_lock);
    check("sync_seen", sync_seen, e_sync);
    check("lock_lost", lock_lost, e_lost);
    check("one_strobe", (int'(out_valid) + int'(sync_seen) + int'(lock_lost)) <= 1, 1);
`ifdef SERDES_DESERIALIZER_ERRCNT_EN
    check("err_count", err_count, e_err);
`endif
    if (out_valid) got.push_back(parallel_out);
    if (sync_seen) n_sync++;
    if (lock_lost) n_lost++;
  end

  task automatic send_bit(input logic b);
    serial_in = b;
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  int base;

  initial begin
    // Reset held with random serial input.
    for (int i = 0; i < 3; i++) begin
      serial_in = 1'($urandom);
      @(negedge clk);
      #1;
    end
    check("rst_par", parallel_out, 8'h00);
    check("rst_valid", out_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_sync", sync_seen, 0);
    check("rst_lost", lock_lost, 0);
    rst = 1'b1;

    // Alignment: 3 random bits, then sync, then 3C.
    for (int i = 0; i < 3; i++) send_bit(1'($urandom));
    send_byte(8'hBC);
    check("align_sync_bit11", sync_seen, 1);
    check("align_locked", locked, 1);
    send_byte(8'h3C);
    check("align_valid_bit19", out_valid, 1);
    check("align_byte", parallel_out, 8'h3C);

    // Sync filtering while locked.
    base = got.size();
    n_sync = 0;
    send_byte(8'hBC);
    send_byte(8'h11);
    send_byte(8'hBC);
    send_byte(8'h22);
    check("filt_count", got.size() - base, 2);
    check("filt_b0", got[base], 8'h11);
    check("filt_b1", got[base+1], 8'h22);
    check("filt_syncs", n_sync, 2);

    // Gap overflow at MAX_GAP=4.
    base = got.size();
    n_lost = 0;
    send_byte(8'hBC);
    for (int k = 1; k <= 4; k++) send_byte(8'(k));
    check("gap_count", got.size() - base, 4);
    check("gap_last", got[got.size()-1], 8'h04);
    send_byte(8'h05);
    check("gap_lost", lock_lost, 1);
    check("gap_unlocked", locked, 0);
    check("gap_hold", parallel_out, 8'h04);
    check("gap_no_05", got.size() - base, 4);
    check("gap_lost_n", n_lost, 1);

    // Reset mid-byte.
    send_byte(8'hBC);
    check("relock", locked, 1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_par", parallel_out, 8'h00);
    check("mid_rst_locked", locked, 0);
    check("mid_rst_valid", out_valid, 0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    base = got.size();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_byte(8'h00);
    send_byte(8'h00);
    check("post_rst_nobyte", got.size() - base, 0);
    check("post_rst_hunt", locked, 0);

`ifdef SERDES_DESERIALIZER_ERRCNT_EN
    for (int n = 0; n < 300; n++) begin
      send_byte(8'hBC);
      for (int k = 1; k <= 5; k++) send_byte(8'(k));
    end
    check("err_sat", err_count, 8'hFF);
    rst = 1'b0;
    #2;
    check("err_clear", err_count, 8'h00);
    @(negedge clk);
    #1;
    rst = 1'b1;
`endif

    send_byte(8'h00);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
